dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master data memory arbiter with bounded bursts, zero-cost switching,
// alignment checking and per-master registered load-response paths.
module dmem_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  localparam logic [3:0] CMAX = 4'(BURST_MAX);

  owner_t      owner;
  logic [3:0]  cnt;
  logic        last;
  logic        gnt0;
  logic        gnt1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        aligned;

  // On a tie the current owner keeps the bus until its burst is used up;
  // from idle the master that was not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (m0_req && !m1_req) begin
        gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        case (owner)
          OWN0: if (cnt < CMAX) gnt0 = 1'b1; else gnt1 = 1'b1;
          OWN1: if (cnt < CMAX) gnt1 = 1'b1; else gnt0 = 1'b1;
          default: if (last) gnt0 = 1'b1; else gnt1 = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    if (gnt0) begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end else if (gnt1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  assign aligned   = (sel_addr[1:0] == 2'b00);
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_read  = (gnt0 | gnt1) & aligned & ~sel_we;
  assign mem_write = (gnt0 | gnt1) & aligned & sel_we;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else if (gnt0) begin
      owner <= OWN0;
      last  <= 1'b0;
      if (owner != OWN0) cnt <= 4'd1;
      else if (cnt < CMAX) cnt <= cnt + 4'd1;
    end else if (gnt1) begin
      owner <= OWN1;
      last  <= 1'b1;
      if (owner != OWN1) cnt <= 4'd1;
      else if (cnt < CMAX) cnt <= cnt + 4'd1;
    end else begin
      owner <= IDLE;
      cnt   <= 4'd0;
    end
  end

  // A misaligned access clears the master's read data instead of loading it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= 32'd0;
    end else begin
      m0_rvalid <= gnt0 & aligned & ~sel_we;
      m0_err    <= gnt0 & ~aligned;
      m1_rvalid <= gnt1 & aligned & ~sel_we;
      m1_err    <= gnt1 & ~aligned;
      if (gnt0 && !aligned) m0_rdata <= 32'd0;
      else if (gnt0 && !sel_we) m0_rdata <= mem_rdata;
      if (gnt1 && !aligned) m1_rdata <= 32'd0;
      else if (gnt1 && !sel_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: rule-level arbitration and memory model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_dmem_arbiter;

  localparam int BURST_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int failures = 0;

  dmem_arbiter #(.BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory seen by the DUT, 64 words.
  logic [31:0] phys [64];
  assign mem_rdata = phys[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) phys[mem_addr[7:2]] = mem_wdata;

  // Reference model state: owner (-1 idle), burst count, last granted.
  int          m_own = -1;
  int          m_cnt = 0;
  int          m_last = 1;
  logic [31:0] model_mem [64];
  logic        exp_rv [2];
  logic        exp_err [2];
  logic [31:0] exp_rdata [2];
  int          dut_wait [2];
  int          mg, cg;
  logic [31:0] ma, ea, ed;
  logic        ewe;

  function automatic logic req_of(int x);   return (x == 0) ? m0_req : m1_req;     endfunction
  function automatic logic we_of(int x);    return (x == 0) ? m0_we : m1_we;       endfunction
  function automatic logic [31:0] addr_of(int x);  return (x == 0) ? m0_addr : m1_addr;   endfunction
  function automatic logic [31:0] wdata_of(int x); return (x == 0) ? m0_wdata : m1_wdata; endfunction

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (!req_of(0) && !req_of(1)) return -1;
    if (req_of(0) && !req_of(1)) return 0;
    if (req_of(1) && !req_of(0)) return 1;
    if (m_own < 0) return 1 - m_last;
    if (m_cnt < BURST_MAX) return m_own;
    return 1 - m_own;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1;
      m_cnt = 0;
      m_last = 1;
      for (int x = 0; x < 2; x++) begin
        exp_rv[x] = 1'b0;
        exp_err[x] = 1'b0;
        exp_rdata[x] = 32'd0;
      end
    end else begin
      mg = model_grant();
      for (int x = 0; x < 2; x++) begin
        exp_rv[x] = 1'b0;
        exp_err[x] = 1'b0;
      end
      if (mg >= 0) begin
        ma = addr_of(mg);
        if (ma[1:0] != 2'b00) begin
          exp_err[mg] = 1'b1;
          exp_rdata[mg] = 32'd0;
        end else if (we_of(mg)) begin
          model_mem[ma[7:2]] = wdata_of(mg);
        end else begin
          exp_rv[mg] = 1'b1;
          exp_rdata[mg] = model_mem[ma[7:2]];
        end
        if (mg == m_own) m_cnt = (m_cnt < BURST_MAX) ? m_cnt + 1 : m_cnt;
        else m_cnt = 1;
        m_own = mg;
        m_last = mg;
      end else begin
        m_own = -1;
        m_cnt = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    cg = model_grant();
    ea = 32'd0;
    ed = 32'd0;
    ewe = 1'b0;
    if (cg >= 0) begin
      ea = addr_of(cg);
      ed = wdata_of(cg);
      ewe = we_of(cg);
    end
    checkOutput("m0_gnt", {31'd0, m0_gnt}, {31'd0, cg == 0});
    checkOutput("m1_gnt", {31'd0, m1_gnt}, {31'd0, cg == 1});
    checkOutput("onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
    checkOutput("mem_read", {31'd0, mem_read}, {31'd0, cg >= 0 && ea[1:0] == 2'b00 && !ewe});
    checkOutput("mem_write", {31'd0, mem_write}, {31'd0, cg >= 0 && ea[1:0] == 2'b00 && ewe});
    checkOutput("mem_addr", mem_addr, ea);
    checkOutput("mem_wdata", mem_wdata, ed);
    checkOutput("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, exp_rv[0]});
    checkOutput("m0_err", {31'd0, m0_err}, {31'd0, exp_err[0]});
    checkOutput("m0_rdata", m0_rdata, exp_rdata[0]);
    checkOutput("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, exp_rv[1]});
    checkOutput("m1_err", {31'd0, m1_err}, {31'd0, exp_err[1]});
    checkOutput("m1_rdata", m1_rdata, exp_rdata[1]);
    for (int x = 0; x < 2; x++) begin
      if (!rst_n || !req_of(x)) dut_wait[x] = 0;
      else if (!((x == 0) ? m0_gnt : m1_gnt)) dut_wait[x]++;
      else dut_wait[x] = 0;
      if (rst_n && req_of(x)) checkOutput("starvation", dut_wait[x], (dut_wait[x] > BURST_MAX) ? 32'(BURST_MAX) : dut_wait[x]);
    end
  end

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  int exp036 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int exp039 [5] = '{0, 0, 0, 0, 1};
  int ridx, rmis;
  logic [31:0] ra0, ra1;

  initial begin
    for (int i = 0; i < 64; i++) begin
      phys[i] = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
    end
    dut_wait[0] = 0;
    dut_wait[1] = 0;
    rst_n = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    #2 rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h4; m1_addr = 32'h8;

    @(negedge clk);
    checkOutput("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
    checkOutput("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
    checkOutput("rst_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    #1;
    m0_req = 1'b0; m1_req = 1'b0;
    rst_n = 1'b1;

    // Continuous tie: bursts of four alternate, starting with master 0.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0);
      checkOutput("r036_gnt0", {31'd0, m0_gnt}, {31'd0, exp036[i] == 0});
      checkOutput("r036_gnt1", {31'd0, m1_gnt}, {31'd0, exp036[i] == 1});
      if (i > 0) begin
        checkOutput("r036_rv0", {31'd0, m0_rvalid}, {31'd0, exp036[i-1] == 0});
        checkOutput("r036_rv1", {31'd0, m1_rvalid}, {31'd0, exp036[i-1] == 1});
      end
    end
    idle();
    checkOutput("r036_last_rv0", {31'd0, m0_rvalid}, 32'd1);
    checkOutput("r036_rdata0", m0_rdata, 32'h1000_0001);
    checkOutput("r036_rdata1", m1_rdata, 32'h1000_0002);

    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r037_st_gnt0", {31'd0, m0_gnt}, 32'd1);
    checkOutput("r037_mem_write", {31'd0, mem_write}, 32'd1);
    checkOutput("r037_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("r037_mem_addr", mem_addr, 32'h10);
    checkOutput("r037_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0);
    checkOutput("r037_ld_gnt1", {31'd0, m1_gnt}, 32'd1);
    checkOutput("r037_ld_read", {31'd0, mem_read}, 32'd1);
    checkOutput("r037_st_no_rv", {31'd0, m0_rvalid}, 32'd0);
    idle();
    checkOutput("r037_rv1", {31'd0, m1_rvalid}, 32'd1);
    checkOutput("r037_rdata1", m1_rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h22, 32'd0);
    checkOutput("r038_gnt1", {31'd0, m1_gnt}, 32'd1);
    checkOutput("r038_read", {31'd0, mem_read}, 32'd0);
    checkOutput("r038_write", {31'd0, mem_write}, 32'd0);
    idle();
    checkOutput("r038_err", {31'd0, m1_err}, 32'd1);
    checkOutput("r038_rv", {31'd0, m1_rvalid}, 32'd0);
    checkOutput("r038_rdata", m1_rdata, 32'd0);
    idle();
    checkOutput("r038_err_pulse", {31'd0, m1_err}, 32'd0);
    checkOutput("r038_rdata_hold", m1_rdata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hC, 32'd0);
      checkOutput("r039_solo_gnt1", {31'd0, m1_gnt}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 1'b0, 32'hC, 32'd0);
      checkOutput("r039_gnt0", {31'd0, m0_gnt}, {31'd0, exp039[i] == 0});
      checkOutput("r039_gnt1", {31'd0, m1_gnt}, {31'd0, exp039[i] == 1});
    end
    idle();

    // Reset strikes while a master 0 load is being granted.
    applyStimulus(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r040_gnt0_a", {31'd0, m0_gnt}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("r040_gnt0_b", {31'd0, m0_gnt}, 32'd1);
    checkOutput("r040_rdata_pre", m0_rdata, 32'h1000_0001);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("r040_gnt_in_rst", {31'd0, m0_gnt}, 32'd0);
    checkOutput("r040_read_in_rst", {31'd0, mem_read}, 32'd0);
    checkOutput("r040_rdata_in_rst", m0_rdata, 32'd0);
    idle();
    #1 rst_n = 1'b1;
    idle();
    checkOutput("r040_no_rv", {31'd0, m0_rvalid}, 32'd0);
    checkOutput("r040_no_err", {31'd0, m0_err}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0);
    checkOutput("r040_tie_gnt0", {31'd0, m0_gnt}, 32'd1);
    checkOutput("r040_tie_gnt1", {31'd0, m1_gnt}, 32'd0);

    // Random traffic, checked by the per-cycle model.
    for (int n = 0; n < 3000; n++) begin
      ridx = $urandom_range(0, 63);
      rmis = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      ra0 = 32'(ridx * 4 + rmis);
      ridx = $urandom_range(0, 63);
      rmis = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      ra1 = 32'(ridx * 4 + rmis);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra0, $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra1, $urandom);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
